// File: rtl/regfile_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if
//   Bundles the writeback arbiter's requester handshakes, load-issue
//   tracking, decode hazard query and register file write port.
//
//   Parameters:
//     DATA_WIDTH    - write data width
//     ADDRESS_WIDTH - register index width
//
//   Signal groups:
//     alu_valid/alu_rd/alu_data/alu_ready  ALU result handshake
//     mem_valid/mem_rd/mem_data/mem_ready  load result handshake
//     mem_issue/mem_issue_rd               load issued to memory
//     rs1/rs2 -> rs1_busy/rs2_busy         decode RAW hazard query
//     we/wr_addr/wr_data                   register file write port
//
//   Modports:
//     slave  - the arbiter
//     master - the execute/memory/decode stages and register file
// ----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     alu_valid;
    logic [ADDRESS_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0]    alu_data;
    logic                     alu_ready;

    logic                     mem_valid;
    logic [ADDRESS_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0]    mem_data;
    logic                     mem_ready;

    logic                     mem_issue;
    logic [ADDRESS_WIDTH-1:0] mem_issue_rd;

    logic [ADDRESS_WIDTH-1:0] rs1;
    logic [ADDRESS_WIDTH-1:0] rs2;
    logic                     rs1_busy;
    logic                     rs2_busy;

    logic                     we;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  mem_issue, mem_issue_rd,
        input  rs1, rs2,
        output rs1_busy, rs2_busy,
        output we, wr_addr, wr_data
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output mem_issue, mem_issue_rd,
        output rs1, rs2,
        input  rs1_busy, rs2_busy,
        input  we, wr_addr, wr_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the register file's single write port between the single-cycle
//   ALU result path and the multi-cycle load path, and keeps a pending bit
//   per register for in-flight loads so decode can stall on RAW hazards.
//
//   Parameters:
//     DATA_WIDTH    - write data width (default 32)
//     ADDRESS_WIDTH - register index width, 2**ADDRESS_WIDTH registers (5)
//     STARVE_LIMIT  - consecutive lost arbitration cycles before MEM is
//                     forced to win (3); only used with the guard enabled
//
//   Ports:
//     clk   - clock, all state updates on posedge
//     rst_n - synchronous active-low reset
//     bus   - regfile_wb_arbiter_if.slave (handshakes, issue tracking,
//             busy query, register file write port)
//
//   Build option:
//     REGFILE_WB_STARVE_GUARD_EN - when defined, a starvation counter forces
//     a MEM grant after STARVE_LIMIT lost cycles; otherwise ALU strictly
//     beats MEM.
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int STARVE_LIMIT  = 3
) (
    input logic                   clk,
    input logic                   rst_n,
    regfile_wb_arbiter_if.slave   bus
);

    localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;

    logic                     mem_force;
    logic                     alu_grant;
    logic                     mem_grant;
    logic [ADDRESS_WIDTH-1:0] grant_rd;
    logic [DATA_WIDTH-1:0]    grant_data;
    logic [NUM_REGS-1:0]      pending;
    logic [NUM_REGS-1:0]      pending_next;

`ifdef REGFILE_WB_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    assign mem_force = bus.mem_valid && (starve_cnt == STARVE_MAX);

    // Counts cycles MEM has been waiting; any cycle MEM is idle or served
    // restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!bus.mem_valid || mem_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign mem_force = 1'b0;
`endif

    // Arbitration: ALU wins unless MEM is being forced after starvation.
    always_comb begin
        alu_grant     = rst_n && bus.alu_valid && !mem_force;
        mem_grant     = rst_n && bus.mem_valid && (!bus.alu_valid || mem_force);
        bus.alu_ready = alu_grant;
        bus.mem_ready = mem_grant;
        grant_rd      = mem_grant ? bus.mem_rd   : bus.alu_rd;
        grant_data    = mem_grant ? bus.mem_data : bus.alu_data;
    end

    // Output stage: x0 writes are accepted but never assert we.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.we      <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else if (alu_grant || mem_grant) begin
            bus.we      <= (grant_rd != '0);
            bus.wr_addr <= grant_rd;
            bus.wr_data <= grant_data;
        end else begin
            bus.we      <= 1'b0;
        end
    end

    // Clear is applied before set so a new load to the same register
    // supersedes the one completing this cycle.
    always_comb begin
        pending_next = pending;
        if (mem_grant) begin
            pending_next[bus.mem_rd] = 1'b0;
        end
        if (bus.mem_issue && (bus.mem_issue_rd != '0)) begin
            pending_next[bus.mem_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // The output-stage term covers the cycle where the write is presented
    // but not yet committed in the register file.
    always_comb begin
        bus.rs1_busy = (bus.rs1 != '0) &&
                       (pending[bus.rs1] || (bus.we && (bus.wr_addr == bus.rs1)));
        bus.rs2_busy = (bus.rs2 != '0) &&
                       (pending[bus.rs2] || (bus.we && (bus.wr_addr == bus.rs2)));
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    regfile_wb_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .STARVE_LIMIT (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.alu_valid    = 1'b0;
        bus.alu_rd       = '0;
        bus.alu_data     = '0;
        bus.mem_valid    = 1'b0;
        bus.mem_rd       = '0;
        bus.mem_data     = '0;
        bus.mem_issue    = 1'b0;
        bus.mem_issue_rd = '0;
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Monitor: every presented register file write is popped against the queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected none",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                    check("wr_data", 64'(bus.wr_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        logic mem_done;
        int   mem_win_cycle;

        idle_inputs();
        bus.rs1 = '0;
        bus.rs2 = '0;

        // Reset with both requesters valid
        rst_n         = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd1;
        bus.alu_data  = 32'h1111_1111;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd2;
        bus.mem_data  = 32'h2222_2222;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
            check("rst_mem_ready", 64'(bus.mem_ready), 64'd0);
        end
        check("rst_we", 64'(bus.we), 64'd0);
        check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        check("rst_wr_data", 64'(bus.wr_data), 64'd0);
        for (int i = 0; i < 32; i++) begin
            bus.rs1 = AW'(i);
            #0.1;
            check("rst_rs1_busy", 64'(bus.rs1_busy), 64'd0);
        end

        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();

        // Single ALU write to x5
        @(negedge clk);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEAD_BEEF;
        bus.rs1       = 5'd5;
        #1;
        check("alu_ready_single", 64'(bus.alu_ready), 64'd1);
        check("rs1_busy_before", 64'(bus.rs1_busy), 64'd0);
        expect_write(5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        idle_inputs();
        #1;
        check("rs1_busy_wb_cycle", 64'(bus.rs1_busy), 64'd1);
        @(negedge clk);
        #1;
        check("rs1_busy_after", 64'(bus.rs1_busy), 64'd0);

        // Contention: both valid, ALU rd=3, MEM rd=4
`ifdef REGFILE_WB_STARVE_GUARD_EN
        mem_win_cycle = 3;
`else
        mem_win_cycle = 6;
`endif
        mem_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.alu_valid = (c < 6);
            bus.alu_rd    = 5'd3;
            bus.alu_data  = 32'hA000_0000 + 32'(c);
            bus.mem_valid = !mem_done;
            bus.mem_rd    = 5'd4;
            bus.mem_data  = 32'hB0B0_B0B0;
            #1;
            if (c == mem_win_cycle) begin
                check("cont_mem_ready", 64'(bus.mem_ready), 64'd1);
                check("cont_alu_ready", 64'(bus.alu_ready), 64'd0);
                expect_write(5'd4, 32'hB0B0_B0B0);
                mem_done = 1'b1;
            end else if (c < 6) begin
                check("cont_mem_ready", 64'(bus.mem_ready), 64'd0);
                check("cont_alu_ready", 64'(bus.alu_ready), 64'd1);
                expect_write(5'd3, 32'hA000_0000 + 32'(c));
            end
        end
        @(negedge clk);
        idle_inputs();

        // Load hazard on x10: issue, result 4 cycles later
        @(negedge clk);
        bus.mem_issue    = 1'b1;
        bus.mem_issue_rd = 5'd10;
        bus.rs2          = 5'd10;
        #1;
        check("load_busy_issue_cycle", 64'(bus.rs2_busy), 64'd0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            check("load_busy_wait", 64'(bus.rs2_busy), 64'd1);
        end
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd10;
        bus.mem_data  = 32'hC0FF_EE00;
        #1;
        check("load_mem_ready", 64'(bus.mem_ready), 64'd1);
        check("load_busy_accept", 64'(bus.rs2_busy), 64'd1);
        expect_write(5'd10, 32'hC0FF_EE00);
        @(negedge clk);
        idle_inputs();
        #1;
        check("load_busy_wb", 64'(bus.rs2_busy), 64'd1);
        @(negedge clk);
        #1;
        check("load_busy_clear", 64'(bus.rs2_busy), 64'd0);

        // x0 write is accepted and dropped
        @(negedge clk);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'h5555_5555;
        #1;
        check("x0_alu_ready", 64'(bus.alu_ready), 64'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("x0_we", 64'(bus.we), 64'd0);

        // Simultaneous set/clear on x7: set wins
        @(negedge clk);
        bus.mem_issue    = 1'b1;
        bus.mem_issue_rd = 5'd7;
        bus.rs1          = 5'd7;
        @(negedge clk);
        bus.mem_valid    = 1'b1;
        bus.mem_rd       = 5'd7;
        bus.mem_data     = 32'h7777_0001;
        bus.mem_issue    = 1'b1;
        bus.mem_issue_rd = 5'd7;
        #1;
        check("sc_mem_ready", 64'(bus.mem_ready), 64'd1);
        expect_write(5'd7, 32'h7777_0001);
        @(negedge clk);
        idle_inputs();
        #1;
        check("sc_busy_wb", 64'(bus.rs1_busy), 64'd1);
        @(negedge clk);
        #1;
        check("sc_pending_kept", 64'(bus.rs1_busy), 64'd1);
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd7;
        bus.mem_data  = 32'h7777_0002;
        #1;
        expect_write(5'd7, 32'h7777_0002);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #1;
        check("sc_busy_clear", 64'(bus.rs1_busy), 64'd0);

        // Mid-operation reset drops pending loads and the output stage
        @(negedge clk);
        bus.mem_issue    = 1'b1;
        bus.mem_issue_rd = 5'd12;
        bus.alu_valid    = 1'b1;
        bus.alu_rd       = 5'd9;
        bus.alu_data     = 32'h9999_9999;
        expect_write(5'd9, 32'h9999_9999);
        @(negedge clk);
        idle_inputs();
        rst_n         = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd11;
        #1;
        check("midrst_alu_ready", 64'(bus.alu_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        bus.rs1 = 5'd12;
        bus.rs2 = 5'd9;
        #1;
        check("midrst_we", 64'(bus.we), 64'd0);
        check("midrst_pending12", 64'(bus.rs1_busy), 64'd0);
        check("midrst_busy9", 64'(bus.rs2_busy), 64'd0);

        repeat (3) @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback arbiter and pending-register scoreboard for the 32-entry register file. Shares the register file's single write port (WE3/rd/WD3) between the single-cycle ALU result path and the multi-cycle memory/load path. Tracks destination registers of in-flight loads so decode can stall on true read-after-write hazards. Sits between the execute/memory stages and the register file write port.

## Interface
Parameters:
- DATA_WIDTH, 32, width of the write data
- ADDRESS_WIDTH, 5, register index width; 2**ADDRESS_WIDTH registers
- STARVE_LIMIT, 3, consecutive lost arbitration cycles after which MEM is forced to win

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- alu_valid  in  1  ALU result available
- alu_rd  in  ADDRESS_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- mem_valid  in  1  load result available
- mem_rd  in  ADDRESS_WIDTH  load destination register
- mem_data  in  DATA_WIDTH  load data
- mem_ready  out  1  load result accepted this cycle
- mem_issue  in  1  load issued to memory this cycle
- mem_issue_rd  in  ADDRESS_WIDTH  destination of the issued load
- rs1, rs2  in  ADDRESS_WIDTH  decode-stage source indices
- rs1_busy, rs2_busy  out  1  source has an unwritten pending result
- we  out  1  drives register file WE3
- wr_addr  out  ADDRESS_WIDTH  drives register file rd
- wr_data  out  DATA_WIDTH  drives register file WD3

## Operation
- Handshake: a transfer occurs when valid && ready in the same cycle. ready is combinational from valid and arbiter state. Requesters hold rd/data stable while valid && !ready.
- Arbitration: at most one grant per cycle. ALU has priority over MEM. Exception: when starve_cnt == STARVE_LIMIT and mem_valid is high, MEM wins.
- starve_cnt rules:
  - Increments when mem_valid && !mem_ready.
  - Clears on a MEM grant or when mem_valid is low.
  - Saturates at STARVE_LIMIT.
- Output stage: the accepted rd/data is registered into wr_addr/wr_data. we is set to 1 unless rd == 0. x0 writes are accepted and dropped. With no grant, we = 0 and wr_addr/wr_data hold their values.
- Scoreboard: pending[2**ADDRESS_WIDTH] bits.
  - mem_issue with mem_issue_rd != 0 sets pending[mem_issue_rd].
  - A MEM grant clears pending[mem_rd].
  - Set and clear of the same index in the same cycle: set wins, because the new load supersedes the old one.
  - pending[0] is never set.
- Busy: rsN_busy = rsN != 0 && (pending[rsN] || (we && wr_addr == rsN)). The output-stage term covers the cycle before the register file edge commits the write.
- ALU results are not scoreboarded. They are visible to busy only through the output-stage term.

## Timing
- Reset (rst_n low at posedge):
  - we = 0, wr_addr = 0, wr_data = 0.
  - All pending bits = 0, starve_cnt = 0.
  - alu_ready = mem_ready = 0 while rst_n is low.
- Accept at posedge N: we/wr_addr/wr_data valid during cycle N+1. The register file is written at posedge N+1. A read in cycle N+2 returns the new value.
- Pending bit: set at the posedge following mem_issue; cleared at the posedge of the MEM accept. The output-stage term then keeps busy high for one more cycle.
- Back-to-back grants are allowed every cycle. Throughput is 1 write per cycle.
- Reset asserted mid-operation discards the pending queue and the output stage. No write is issued in the reset cycle.
- Both valid with the same rd: ALU writes first (unless MEM is forced), then MEM in a later cycle. The last write wins in the register file.

## Configuration
- REGFILE_WB_STARVE_GUARD_EN defined: the starvation counter and the forced MEM grant are as described above.
- REGFILE_WB_STARVE_GUARD_EN undefined: strict ALU > MEM priority. No starve_cnt logic. STARVE_LIMIT is ignored. MEM can wait indefinitely under continuous ALU traffic.

## Test plan
- Reset: hold rst_n = 0 with both valid = 1 -> readies = 0, we = 0, rs1_busy = 0 for all rs1.
- Single ALU write: alu_rd = 5, alu_data = 0xDEADBEEF, accepted at edge N -> we = 1, wr_addr = 5, wr_data = 0xDEADBEEF in cycle N+1; rs1 = 5 busy only in cycle N+1.
- Contention: alu_valid and mem_valid held high (alu_rd = 3, mem_rd = 4) -> ALU granted 3 cycles, MEM granted on the 4th with guard enabled; MEM never granted with guard disabled.
- Load hazard: mem_issue with rd = 10, then mem_valid 4 cycles later -> rs2 = 10 busy from the cycle after issue through the cycle of we = 1, clear afterward.
- x0 and simultaneous set/clear: ALU write to rd = 0 accepted -> we = 0. mem_issue_rd = 7 in the same cycle as a MEM grant to rd = 7 -> pending[7] stays 1.
